// File: rtl/fwd_pkg.sv
// Shared definitions for the SimpleRISC forwarding/hazard unit: register-address
// width helper, the hardwired-zero register number and the forward-source enum.
package fwd_pkg;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_DM = 2'd1,
    FWD_WB = 2'd2
  } fwd_src_e;

  function automatic int rw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit: EX operands, DM/WB write-back
// info, ID hazard inputs, and the forwarded operands / stall controls coming back.
interface fwd_hazard_unit_if
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int PCW  = 16
);
  localparam int RW = rw_of(NREG);

  logic [NRP*RW-1:0]   rp_ex;
  logic [NRP*XLEN-1:0] op_ex;
  logic [NRP*XLEN-1:0] fwd_op;
  fwd_src_e [NRP-1:0]  fwd_src;
  logic [RW-1:0]       rd_dm;
  logic                dm_we;
  logic                dm_is_load;
  logic [XLEN-1:0]     result_dm;
  logic [RW-1:0]       rd_wb;
  logic                wb_we;
  logic [XLEN-1:0]     result_wb;
  logic [NRP*RW-1:0]   rp_id;
  logic [RW-1:0]       rd_id;
  logic                id_we;
  logic [RW-1:0]       rd_ex;
  logic                ex_we;
  logic                ex_is_load;
  logic                long_issue;
  logic                stall_id;
  logic                bubble_ex;
  logic [NREG-1:0]     busy_vec;
  logic [PCW-1:0]      stall_cnt;

  modport slave (
    input  rp_ex, op_ex, rd_dm, dm_we, dm_is_load, result_dm, rd_wb, wb_we, result_wb,
           rp_id, rd_id, id_we, rd_ex, ex_we, ex_is_load, long_issue,
    output fwd_op, fwd_src, stall_id, bubble_ex, busy_vec, stall_cnt
  );

  modport master (
    output rp_ex, op_ex, rd_dm, dm_we, dm_is_load, result_dm, rd_wb, wb_we, result_wb,
           rp_id, rd_id, id_we, rd_ex, ex_we, ex_is_load, long_issue,
    input  fwd_op, fwd_src, stall_id, bubble_ex, busy_vec, stall_cnt
  );

endinterface

// File: rtl/fwd_mux.sv
// Single read-port operand bypass: DM result beats WB result beats regfile value.
// Loads in DM have no data yet, so they never forward from DM.
module fwd_mux
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic [RW-1:0]   rp,
  input  logic [XLEN-1:0] op_rf,
  input  logic [RW-1:0]   rd_dm,
  input  logic            dm_we,
  input  logic            dm_is_load,
  input  logic [XLEN-1:0] result_dm,
  input  logic [RW-1:0]   rd_wb,
  input  logic            wb_we,
  input  logic [XLEN-1:0] result_wb,
  output logic [XLEN-1:0] op,
  output fwd_src_e        src
);
  localparam logic [RW-1:0] R0 = RW'(REG_ZERO);

  always_comb begin
    // NOTE: defaults first so every path assigns op/src and no latch is inferred.
    op  = op_rf;
    src = FWD_RF;
    if (rp != R0 && rp == rd_dm && dm_we && !dm_is_load) begin
      op  = result_dm;
      src = FWD_DM;
    end else if (rp != R0 && rp == rd_wb && wb_we) begin
      op  = result_wb;
      src = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding for NRP read ports plus load-use / long-op scoreboard stall
// generation and a saturating stalled-cycle counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRP     = 2,
  parameter int MUL_LAT = 4,
  parameter int PCW     = 16
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave bus
);
  localparam int RW = rw_of(NREG);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [RW-1:0] R0  = RW'(REG_ZERO);
  localparam logic [CW-1:0] LAT = CW'(MUL_LAT);

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] busy;
  logic [PCW-1:0]  stall_cnt_q;
  logic            load_use, sb_haz, waw, stall, accept;

  for (genvar g = 0; g < NRP; g++) begin : g_port
    fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_mux (
      .rp         (bus.rp_ex[g*RW +: RW]),
      .op_rf      (bus.op_ex[g*XLEN +: XLEN]),
      .rd_dm      (bus.rd_dm),
      .dm_we      (bus.dm_we),
      .dm_is_load (bus.dm_is_load),
      .result_dm  (bus.result_dm),
      .rd_wb      (bus.rd_wb),
      .wb_we      (bus.wb_we),
      .result_wb  (bus.result_wb),
      .op         (bus.fwd_op[g*XLEN +: XLEN]),
      .src        (bus.fwd_src[g])
    );
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) busy[r] = (cnt[r] != '0);
  end

  always_comb begin
    load_use = 1'b0;
    sb_haz   = 1'b0;
    for (int j = 0; j < NRP; j++) begin
      if (bus.ex_we && bus.ex_is_load && bus.rd_ex != R0 && bus.rp_id[j*RW +: RW] == bus.rd_ex)
        load_use = 1'b1;
      if (bus.rp_id[j*RW +: RW] != R0 && busy[bus.rp_id[j*RW +: RW]])
        sb_haz = 1'b1;
    end
    waw    = bus.id_we && bus.rd_id != R0 && busy[bus.rd_id];
    stall  = load_use || sb_haz || waw;
    accept = bus.long_issue && !stall && bus.rd_id != R0;
  end

  // Counters are cleared by reset so that pending long ops vanish the instant rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        // NOTE: non-blocking so every counter updates from the pre-edge state.
        if (accept && bus.rd_id == RW'(r)) cnt[r] <= LAT;
        else if (cnt[r] != '0)              cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + PCW'(1);
  end

  assign bus.stall_id  = stall;
  assign bus.bubble_ex = stall;
  assign bus.busy_vec  = busy;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
